// File: rtl/absval_pkg.sv
// Shared constants, FSM encoding and width helper for the absval stage and its SAD accumulator.
package absval_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned BLK_LEN_DEF = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } sad_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'(1) << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/absval_sad_core.sv
// Accumulator, sample counter and peak tracker for one block.
// Peak logic is built only when ABSVAL_SAD_PEAK_EN is defined.
module absval_sad_core import absval_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             acc_en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [ACC_W-1:0] acc_nxt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic [WIDTH-1:0] peak_nxt_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Zero-extension keeps 8'h80 as +128.
  assign acc_nxt_o = acc_q + ACC_W'(sample_i);
  assign cnt_nxt_o = cnt_q + CNT_W'(1);
  assign cnt_o     = cnt_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_nxt_o;
      cnt_d = cnt_nxt_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef ABSVAL_SAD_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  assign peak_nxt_o = (sample_i > peak_q) ? sample_i : peak_q;

  always_comb begin
    peak_d = peak_q;
    if (clr_i) begin
      peak_d = '0;
    end else if (acc_en_i) begin
      peak_d = peak_nxt_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end
`else
  assign peak_nxt_o = '0;
`endif

endmodule

// File: rtl/absval_sad_accum.sv
// Streaming sum-of-absolute-values block accumulator with valid/ready result handshake.
// Optional peak tracking is enabled by defining ABSVAL_SAD_PEAK_EN.
module absval_sad_accum import absval_pkg::*; #(
  parameter  int unsigned WIDTH   = WIDTH_DEF,
  parameter  int unsigned BLK_LEN = BLK_LEN_DEF,
  localparam int unsigned CNT_W   = clog2(BLK_LEN + 1),
  localparam int unsigned ACC_W   = WIDTH + clog2(BLK_LEN)
) (
  input  logic             inst_clk,
  input  logic             inst_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_absval,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [WIDTH-1:0] out_peak
);

  sad_state_e state_q, state_d;

  logic             accept, close;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] peak_nxt;

  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  absval_sad_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_core (
    .clk_i      (inst_clk),
    .rst_i      (inst_rst),
    .acc_en_i   (accept),
    .clr_i      (close),
    .sample_i   (in_absval),
    .cnt_o      (cnt),
    .acc_nxt_o  (acc_nxt),
    .cnt_nxt_o  (cnt_nxt),
    .peak_nxt_o (peak_nxt)
  );

  // Gated by reset so in_ready is low during reset and high right after release.
  assign in_ready  = ~inst_rst & (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid & in_ready;
  assign close     = accept & (in_last | (cnt == CNT_W'(BLK_LEN - 1)));

  always_comb begin
    state_d     = state_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (close) begin
          state_d     = ST_HOLD;
          out_sum_d   = acc_nxt;
          out_count_d = cnt_nxt;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge inst_clk or posedge inst_rst) begin
    if (inst_rst) begin
      state_q     <= ST_ACCUM;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

`ifdef ABSVAL_SAD_PEAK_EN
  logic [WIDTH-1:0] out_peak_q, out_peak_d;

  always_comb begin
    out_peak_d = out_peak_q;
    if (close) out_peak_d = peak_nxt;
  end

  always_ff @(posedge inst_clk or posedge inst_rst) begin
    if (inst_rst) begin
      out_peak_q <= '0;
    end else begin
      out_peak_q <= out_peak_d;
    end
  end

  assign out_peak = out_peak_q;
`else
  // Core drives a constant zero when peak tracking is not built.
  assign out_peak = peak_nxt;
`endif

endmodule

// File: tb/tb_absval_sad_accum.sv
// Directed, table-driven bench for absval_sad_accum (WIDTH=8, BLK_LEN=16).
module tb_absval_sad_accum;

  logic        inst_clk = 1'b0;
  logic        inst_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_absval = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_sum;
  logic [4:0]  out_count;
  logic [7:0]  out_peak;

  absval_sad_accum #(
    .WIDTH   (8),
    .BLK_LEN (16)
  ) dut (
    .inst_clk  (inst_clk),
    .inst_rst  (inst_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_absval (in_absval),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_peak  (out_peak)
  );

  always #5 inst_clk = ~inst_clk;

  typedef struct packed {
    int           n;
    logic [127:0] s;
    logic         last;
    int           sum;
    int           cnt;
    int           pk;
  } vec_t;

  vec_t vecs [5];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pk(input int p);
`ifdef ABSVAL_SAD_PEAK_EN
    return p;
`else
    return p & 0;
`endif
  endfunction

  task automatic beat(input logic [7:0] v, input logic last);
    in_valid  = 1'b1;
    in_absval = v;
    in_last   = last;
    @(posedge inst_clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int sum, input int cnt, input int p);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " in_ready"},  32'(in_ready),  32'd0);
    chk({tag, " out_sum"},   32'(out_sum),   32'(sum));
    chk({tag, " out_count"}, 32'(out_count), 32'(cnt));
    chk({tag, " out_peak"},  32'(out_peak),  32'(pk(p)));
  endtask

  initial begin
    vecs[0] = '{n: 16, s: '0, last: 1'b0, sum: 136,  cnt: 16, pk: 16};
    vecs[1] = '{n: 3,  s: '0, last: 1'b1, sum: 212,  cnt: 3,  pk: 200};
    vecs[2] = '{n: 16, s: '0, last: 1'b0, sum: 4080, cnt: 16, pk: 255};
    vecs[3] = '{n: 1,  s: '0, last: 1'b1, sum: 128,  cnt: 1,  pk: 128};
    vecs[4] = '{n: 16, s: '0, last: 1'b1, sum: 32,   cnt: 16, pk: 2};
    for (int i = 0; i < 16; i++) begin
      vecs[0].s[i*8 +: 8] = 8'(i + 1);
      vecs[2].s[i*8 +: 8] = 8'hFF;
      vecs[4].s[i*8 +: 8] = 8'd2;
    end
    vecs[1].s[23:0] = {8'd7, 8'd200, 8'd5};
    vecs[3].s[7:0]  = 8'h80;

    // Reset state
    #12;
    chk("rst in_ready",  32'(in_ready),  32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_sum",   32'(out_sum),   32'd0);
    chk("rst out_count", 32'(out_count), 32'd0);
    chk("rst out_peak",  32'(out_peak),  32'd0);
    @(posedge inst_clk);
    #1 inst_rst = 1'b0;
    #1 chk("release in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].n - 1; j++) beat(vecs[v].s[j*8 +: 8], 1'b0);
      chk($sformatf("vec%0d pre-close out_valid", v), 32'(out_valid), 32'd0);
      beat(vecs[v].s[(vecs[v].n-1)*8 +: 8], vecs[v].last);
      chk_result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].cnt, vecs[v].pk);
      @(posedge inst_clk);
      #1;
      chk($sformatf("vec%0d post out_valid", v), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d post in_ready", v),  32'(in_ready),  32'd1);
      chk($sformatf("vec%0d kept out_sum", v),   32'(out_sum),   32'(vecs[v].sum));
      @(posedge inst_clk);
      #1 chk($sformatf("vec%0d no extra block", v), 32'(out_valid), 32'd0);
    end

    // Backpressure with upstream pushing 9 while held
    out_ready = 1'b0;
    beat(8'd3, 1'b0);
    beat(8'd4, 1'b1);
    chk_result("bp close", 7, 2, 4);
    in_valid  = 1'b1;
    in_absval = 8'd9;
    for (int k = 0; k < 10; k++) begin
      @(posedge inst_clk);
      #1;
      chk($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d in_ready", k),  32'(in_ready),  32'd0);
      chk($sformatf("bp%0d out_sum", k),   32'(out_sum),   32'd7);
      chk($sformatf("bp%0d out_count", k), 32'(out_count), 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge inst_clk);
    #1 chk("bp release out_valid", 32'(out_valid), 32'd0);
    beat(8'd9, 1'b1);
    chk_result("bp fresh block", 9, 1, 9);
    @(posedge inst_clk);
    #1;

    // in_last without in_valid
    in_last = 1'b1;
    @(posedge inst_clk);
    #1 in_last = 1'b0;
    chk("lone last out_valid", 32'(out_valid), 32'd0);
    chk("lone last out_sum",   32'(out_sum),   32'd9);

    // Reset while holding a result
    out_ready = 1'b0;
    beat(8'd7, 1'b1);
    chk("hold out_valid", 32'(out_valid), 32'd1);
    #2 inst_rst = 1'b1;
    #1;
    chk("hold rst out_valid", 32'(out_valid), 32'd0);
    chk("hold rst in_ready",  32'(in_ready),  32'd0);
    chk("hold rst out_sum",   32'(out_sum),   32'd0);
    chk("hold rst out_count", 32'(out_count), 32'd0);
    @(posedge inst_clk);
    #1 inst_rst = 1'b0;
    #1 chk("hold rel in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Reset mid-block discards the partial sum
    for (int k = 0; k < 5; k++) beat(8'd50, 1'b0);
    #2 inst_rst = 1'b1;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst in_ready",  32'(in_ready),  32'd0);
    @(posedge inst_clk);
    #1 inst_rst = 1'b0;
    for (int k = 0; k < 15; k++) beat(8'd1, 1'b0);
    chk("mid rst pre-close out_valid", 32'(out_valid), 32'd0);
    beat(8'd1, 1'b0);
    chk_result("mid rst block", 16, 16, 1);
    @(posedge inst_clk);
    #1 chk("final out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
